// File: rtl/aes_core_arbiter_pkg.sv
// Shared types and helpers for the AES core arbiter (op codes, FSM states, job payload).
package aes_core_arbiter_pkg;

  localparam int unsigned BLK_S = 128;
  localparam int unsigned KEY_S = 256;
  localparam int unsigned OP_W  = 2;

  typedef enum logic [1:0] {
    AES_ARB_OP_KEYEXP = 2'b00,
    AES_ARB_OP_ENC    = 2'b01,
    AES_ARB_OP_DEC    = 2'b10,
    AES_ARB_OP_ILL    = 2'b11
  } arb_op_e;

  typedef enum logic [2:0] {
    ST_ARB    = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

  // Op captured at the request handshake and presented to the core.
  typedef struct packed {
    arb_op_e          op;
    logic [KEY_S-1:0] key;
    logic [BLK_S-1:0] blk;
    logic             last;
  } arb_job_t;

  // Mode bits toward the core; key size plus one-hot operation.
  typedef struct packed {
    logic aes128;
    logic aes256;
    logic key_exp;
    logic cipher;
    logic decipher;
  } arb_mode_t;

  // Ceiling log2 with a floor of 1 so a 1-bit index always exists.
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = unsigned'(i) + 32'd1;
    end
    return r;
  endfunction

  function automatic arb_mode_t mode_of(input arb_op_e op, input logic key256);
    arb_mode_t m;
    m.aes128   = ~key256;
    m.aes256   = key256;
    m.key_exp  = (op == AES_ARB_OP_KEYEXP);
    m.cipher   = (op == AES_ARB_OP_ENC);
    m.decipher = (op == AES_ARB_OP_DEC);
    return m;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of i_valid at or above i_rr_ptr, wrapping.
module aes_core_arbiter_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    w_dbl = {i_valid, i_valid};
    w_rot = N'(w_dbl >> i_rr_ptr);
    w_off = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
    w_sum = (IDX_W+1)'(i_rr_ptr) + (IDX_W+1)'(w_off);
    if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
    o_idx_c = IDX_W'(w_sum);
    o_any_c = |i_valid;
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between NUM_REQ requesters; a grant lasts for a whole job.
// Optional per-requester completed-block counters on stat_blocks when AES_ARB_STATS_EN is defined.
module aes_core_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = clogb2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [OP_W*NUM_REQ-1:0]  req_op,
  input  logic [NUM_REQ-1:0]       req_key256,
  input  logic [KEY_S*NUM_REQ-1:0] req_key,
  input  logic [BLK_S*NUM_REQ-1:0] req_blk,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [BLK_S-1:0]         rsp_blk,
  output logic                     rsp_last,
  output logic                     core_en,
  output logic                     core_aes128_mode,
  output logic                     core_aes256_mode,
  output logic                     core_key_exp_mode,
  output logic                     core_cipher_mode,
  output logic                     core_decipher_mode,
  output logic [KEY_S-1:0]         core_key,
  output logic [BLK_S-1:0]         core_in_blk,
  input  logic [BLK_S-1:0]         core_out_blk,
  input  logic                     core_done,
  input  logic                     core_busy,
  output logic [IDX_W-1:0]         grant_idx,
`ifdef AES_ARB_STATS_EN
  output logic [32*NUM_REQ-1:0]    stat_blocks,
`endif
  output logic                     illegal_op
);

  arb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]   r_grant_idx, w_grant_nxt;
  arb_job_t           r_job, w_job_nxt, w_sel_job;
  arb_mode_t          r_mode, w_mode_nxt;
  logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic [BLK_S-1:0]   r_rsp_blk, w_rsp_blk_nxt;
  logic               r_rsp_last, w_rsp_last_nxt;
  logic               r_core_en, w_core_en_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               w_release;
  logic [IDX_W-1:0]   w_rel_ptr;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_hs;
  logic               w_rsp_hs;
  logic [NUM_REQ-1:0] w_grant_oh;

  aes_core_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_valid  (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_idx_c  (w_pick_idx),
    .o_any_c  (w_pick_any)
  );

  // Only the owner may hand over an op, and only while the core is idle.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_ACCEPT && !core_busy) req_ready[r_grant_idx] = 1'b1;
  end

  // Mux the granted requester's op fields and derive handshake/release helpers.
  always_comb begin
    w_sel_job.op   = arb_op_e'(req_op[OP_W*r_grant_idx +: OP_W]);
    w_sel_job.key  = req_key[KEY_S*r_grant_idx +: KEY_S];
    w_sel_job.blk  = req_blk[BLK_S*r_grant_idx +: BLK_S];
    w_sel_job.last = req_last[r_grant_idx];
    w_hs           = req_valid[r_grant_idx] & req_ready[r_grant_idx];
    w_rsp_hs       = |(r_rsp_valid & rsp_ready);
    w_grant_oh     = NUM_REQ'(1) << r_grant_idx;
    w_rel_ptr      = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(r_grant_idx + 1'b1);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_nxt     = r_grant_idx;
    w_job_nxt       = r_job;
    w_mode_nxt      = r_mode;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_blk_nxt   = r_rsp_blk;
    w_rsp_last_nxt  = r_rsp_last;
    w_core_en_nxt   = 1'b0;
    w_illegal_nxt   = 1'b0;
    w_release       = 1'b0;
    unique case (r_state)
      ST_ARB: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (w_hs) begin
          w_job_nxt = w_sel_job;
          if (w_sel_job.op == AES_ARB_OP_ILL) begin
            w_illegal_nxt = 1'b1;
            w_release     = w_sel_job.last;
          end else begin
            w_mode_nxt    = mode_of(w_sel_job.op, req_key256[r_grant_idx]);
            w_core_en_nxt = 1'b1;
            w_state_nxt   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          if (r_job.op == AES_ARB_OP_KEYEXP) begin
            if (r_job.last) w_release = 1'b1;
            else            w_state_nxt = ST_ACCEPT;
          end else begin
            w_rsp_blk_nxt   = core_out_blk;
            w_rsp_last_nxt  = r_job.last;
            w_rsp_valid_nxt = w_grant_oh;
            w_state_nxt     = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_rsp_valid_nxt = '0;
          if (r_rsp_last) w_release = 1'b1;
          else            w_state_nxt = ST_ACCEPT;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
    if (w_release) begin
      w_state_nxt  = ST_ARB;
      w_rr_ptr_nxt = w_rel_ptr;
      w_mode_nxt   = '0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_ARB;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_mode      <= '0;
      r_rsp_valid <= '0;
      r_core_en   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant_idx <= w_grant_nxt;
      r_mode      <= w_mode_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_core_en   <= w_core_en_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

  // Data path registers; contents are only meaningful while qualified by control state.
  always_ff @(posedge clk) begin
    r_job      <= w_job_nxt;
    r_rsp_blk  <= w_rsp_blk_nxt;
    r_rsp_last <= w_rsp_last_nxt;
  end

`ifdef AES_ARB_STATS_EN
  logic [32*NUM_REQ-1:0] r_stat;

  // Count delivered result blocks per requester.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stat <= '0;
    end else if (r_state == ST_RESP && w_rsp_hs) begin
      r_stat[32*r_grant_idx +: 32] <= r_stat[32*r_grant_idx +: 32] + 32'd1;
    end
  end

  assign stat_blocks = r_stat;
`endif

  assign rsp_valid          = r_rsp_valid;
  assign rsp_blk            = r_rsp_blk;
  assign rsp_last           = r_rsp_last;
  assign core_en            = r_core_en;
  assign core_aes128_mode   = r_mode.aes128;
  assign core_aes256_mode   = r_mode.aes256;
  assign core_key_exp_mode  = r_mode.key_exp;
  assign core_cipher_mode   = r_mode.cipher;
  assign core_decipher_mode = r_mode.decipher;
  assign core_key           = r_job.key;
  assign core_in_blk        = r_job.blk;
  assign grant_idx          = r_grant_idx;
  assign illegal_op         = r_illegal;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a small behavioural stand-in for the AES core.
module tb_aes_core_arbiter;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] X     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] NX    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] Y     = 128'hffffffff000000001111111122222222;
  localparam logic [127:0] NY    = 128'h00000000ffffffffeeeeeeeedddddddd;

  logic         clk = 1'b0;
  logic         resetn;
  logic [1:0]   req_valid, req_ready, req_key256, req_last, rsp_valid, rsp_ready;
  logic [3:0]   req_op;
  logic [511:0] req_key;
  logic [255:0] req_blk;
  logic [127:0] rsp_blk, core_in_blk, core_out_blk;
  logic [255:0] core_key;
  logic         rsp_last, core_en, core_done, core_busy, illegal_op;
  logic         core_aes128_mode, core_aes256_mode, core_key_exp_mode, core_cipher_mode, core_decipher_mode;
  logic [0:0]   grant_idx;
`ifdef AES_ARB_STATS_EN
  logic [63:0]  stat_blocks;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int en_count = 0;
  int rsp_hs  = 0;
  int ill_cnt = 0;

  logic         m_busy, m_done, inj_done;
  logic [1:0]   m_cnt;
  logic [127:0] m_out;
  logic         c_enc, c_dec;
  logic [255:0] c_key;
  logic [127:0] c_blk;

  always #5 clk = ~clk;

  aes_core_arbiter #(.NUM_REQ(2)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_key256         (req_key256),
    .req_key            (req_key),
    .req_blk            (req_blk),
    .req_last           (req_last),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_blk            (rsp_blk),
    .rsp_last           (rsp_last),
    .core_en            (core_en),
    .core_aes128_mode   (core_aes128_mode),
    .core_aes256_mode   (core_aes256_mode),
    .core_key_exp_mode  (core_key_exp_mode),
    .core_cipher_mode   (core_cipher_mode),
    .core_decipher_mode (core_decipher_mode),
    .core_key           (core_key),
    .core_in_blk        (core_in_blk),
    .core_out_blk       (core_out_blk),
    .core_done          (core_done),
    .core_busy          (core_busy),
    .grant_idx          (grant_idx),
`ifdef AES_ARB_STATS_EN
    .stat_blocks        (stat_blocks),
`endif
    .illegal_op         (illegal_op)
  );

  // Known-answer lookup for the FIPS vectors, simple invertible transforms otherwise.
  function automatic logic [127:0] core_fn(input logic enc, input logic dec,
                                           input logic [255:0] key, input logic [127:0] blk);
    if (enc && key == K128 && blk == PT)    return C128;
    if (dec && key == K256 && blk == CT256) return PT;
    if (enc) return ~blk;
    if (dec) return blk ^ {4{32'h5a5a5a5a}};
    return blk;
  endfunction

  // Stand-in core: busy for three cycles after core_en, then a one-cycle done with the result.
  always @(posedge clk) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 2'd0;
    end else begin
      m_done <= 1'b0;
      if (core_en) begin
        m_busy   <= 1'b1;
        m_cnt    <= 2'd3;
        en_count <= en_count + 1;
        c_enc    <= core_cipher_mode;
        c_dec    <= core_decipher_mode;
        c_key    <= core_key;
        c_blk    <= core_in_blk;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 2'd1;
        if (m_cnt == 2'd1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_out  <= core_fn(c_enc, c_dec, c_key, c_blk);
        end
      end
    end
  end

  assign core_done    = m_done | inj_done;
  assign core_busy    = m_busy;
  assign core_out_blk = m_out;

  // Event counters for response handshakes and illegal-op pulses.
  always @(posedge clk) begin
    if (resetn) begin
      if (|(rsp_valid & rsp_ready)) rsp_hs <= rsp_hs + 1;
      if (illegal_op) ill_cnt <= ill_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic k256,
                         input logic [255:0] key, input logic [127:0] blk, input logic last);
    req_op[2*r +: 2]      = op;
    req_key256[r]         = k256;
    req_key[256*r +: 256] = key;
    req_blk[128*r +: 128] = blk;
    req_last[r]           = last;
    req_valid[r]          = 1'b1;
  endtask

  task automatic send_op(input int r, input logic [1:0] op, input logic k256,
                         input logic [255:0] key, input logic [127:0] blk, input logic last);
    int n;
    logic [1:0] oh;
    oh = 2'b01 << r;
    set_req(r, op, k256, key, blk, last);
    n = 0;
    while (!req_ready[r] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[r]) begin
      check("accept_timeout", 256'd0, 256'd1);
      req_valid[r] = 1'b0;
      return;
    end
    check("ready_onehot", 256'(req_ready), 256'(oh));
    check("grant_idx", 256'(grant_idx), 256'(r));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    if (op == 2'b11) begin
      check("illegal_pulse", 256'(illegal_op), 256'd1);
      check("illegal_no_en", 256'(core_en), 256'd0);
    end else begin
      check("core_en", 256'(core_en), 256'd1);
      check("core_mode",
            256'({core_aes128_mode, core_aes256_mode, core_key_exp_mode, core_cipher_mode, core_decipher_mode}),
            256'({~k256, k256, op == 2'b00, op == 2'b01, op == 2'b10}));
      check("core_key", core_key, key);
      check("core_blk", 256'(core_in_blk), 256'(blk));
    end
  endtask

  task automatic wait_rsp(input int r, input logic [127:0] exp_blk, input logic exp_last, input int hold);
    int n;
    int en0;
    logic ok;
    logic [1:0] oh;
    oh = 2'b01 << r;
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_valid", 256'(rsp_valid), 256'(oh));
    if (rsp_valid == 2'b00) return;
    check("rsp_blk", 256'(rsp_blk), 256'(exp_blk));
    check("rsp_last", 256'(rsp_last), 256'(exp_last));
    if (hold > 0) begin
      en0 = en_count;
      ok  = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (rsp_valid != oh || rsp_blk != exp_blk || req_ready != 2'b00) ok = 1'b0;
      end
      check("hold_stable", 256'(ok), 256'd1);
      check("hold_no_en", 256'(en_count), 256'(en0));
    end
    rsp_ready[r] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[r] = 1'b0;
    check("rsp_drop", 256'(rsp_valid), 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 256'({req_ready, rsp_valid, core_en, core_aes128_mode, core_aes256_mode,
                     core_key_exp_mode, core_cipher_mode, core_decipher_mode, grant_idx, illegal_op}),
          256'd0);
  endtask

  initial begin
    int en0;
    resetn     = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_key256 = '0;
    req_key    = '0;
    req_blk    = '0;
    req_last   = '0;
    rsp_ready  = '0;
    inj_done   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;

    // A done pulse while idle must not produce a response.
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    @(posedge clk); #1;
    check("stray_done", 256'({rsp_valid, req_ready, core_en}), 256'd0);

    // Both requesters valid from reset; req0's 3-op job runs first.
    set_req(1, 2'b00, 1'b1, K256, 128'd0, 1'b0);
    send_op(0, 2'b00, 1'b0, K128, 128'd0, 1'b0);
    send_op(0, 2'b01, 1'b0, K128, PT, 1'b0);
    wait_rsp(0, C128, 1'b0, 0);
    send_op(0, 2'b01, 1'b0, K128, X, 1'b1);
    wait_rsp(0, NX, 1'b1, 0);
    check("release_ready", 256'(req_ready), 256'd0);
    check("release_mode", 256'({core_aes128_mode, core_cipher_mode}), 256'd0);

    // req1's job (256-bit key exp + decrypt) while req0 waits again.
    set_req(0, 2'b01, 1'b0, K128, PT, 1'b1);
    send_op(1, 2'b00, 1'b1, K256, 128'd0, 1'b0);
    send_op(1, 2'b10, 1'b1, K256, CT256, 1'b0);
    wait_rsp(1, PT, 1'b0, 0);
    check("aes256_held", 256'(core_aes256_mode), 256'd1);
    send_op(1, 2'b01, 1'b1, K256, Y, 1'b1);
    wait_rsp(1, NY, 1'b1, 0);

    // req0 granted again; response back-pressured for 20 cycles.
    send_op(0, 2'b01, 1'b0, K128, PT, 1'b1);
    wait_rsp(0, C128, 1'b1, 20);

    // rr_ptr now points at req1: it wins over req0 and issues an illegal op.
    set_req(0, 2'b01, 1'b0, K128, X, 1'b1);
    en0 = en_count;
    send_op(1, 2'b11, 1'b0, 256'd0, 128'd0, 1'b1);
    check("illegal_release", 256'(req_ready), 256'd0);
    @(posedge clk); #1;
    check("illegal_once", 256'(illegal_op), 256'd0);
    check("illegal_no_core", 256'({en_count == en0, rsp_valid}), 256'({1'b1, 2'b00}));

    // req0 takes the grant; reset lands while the core is working.
    send_op(0, 2'b01, 1'b0, K128, X, 1'b1);
    @(posedge clk); #1;
    resetn    = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    check_reset_outputs("mid_wait_reset");
`ifdef AES_ARB_STATS_EN
    check("stat_after_reset", 256'(stat_blocks), 256'd0);
`endif
    resetn = 1'b1;
    @(posedge clk); #1;

    // Fresh job after the abort.
    send_op(0, 2'b01, 1'b0, K128, PT, 1'b1);
    wait_rsp(0, C128, 1'b1, 0);
`ifdef AES_ARB_STATS_EN
    check("stat_fresh", 256'(stat_blocks), 256'({32'd0, 32'd1}));
`endif

    check("rsp_handshakes", 256'(rsp_hs), 256'd6);
    check("illegal_count", 256'(ill_cnt), 256'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
